bn128_multiexp_in_demux: RTL



---
 rtl/bn128_pkg.sv | 14 +
 rtl/if_axi_stream.sv | 15 +
 rtl/bn128_multiexp_in_demux.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/bn128_pkg.sv
// Shared BN128 field-element type and host element word order.
package bn128_pkg;

   localparam int FE_BITS = 256;

   typedef logic [FE_BITS-1:0] fe_t;

   typedef enum logic [1:0] {
      WORD_SCL,
      WORD_X,
      WORD_Y
   } word_e;

endpackage

// File: rtl/if_axi_stream.sv
// Minimal valid/ready stream with start/end-of-packet framing.
interface if_axi_stream #(
   parameter int DAT_BITS = 256
);

   logic [DAT_BITS-1:0] dat;
   logic                val;
   logic                rdy;
   logic                sop;
   logic                eop;

   modport sink (input dat, val, sop, eop, output rdy);
   modport source (output dat, val, sop, eop, input rdy);

endinterface

// File: rtl/bn128_multiexp_in_demux.sv
// Splits the host word stream (scalar, x, y per element) into framed
// scalar and point streams for the G1 multiexp wrapper.
module bn128_multiexp_in_demux
   import bn128_pkg::*;
#(
   parameter int NUM_BITS = $bits(fe_t)
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [63:0]  i_num_in,
   if_axi_stream.sink   i_host_if,
   if_axi_stream.source o_scl_if,
   if_axi_stream.source o_pnt_if,
   output logic         o_busy,
   output logic         o_err
);

   typedef enum logic [2:0] {IDLE, SCL, PX, PY, DRAIN} state_e;

   state_e              state;
   state_e              state_n;
   logic [63:0]         num_r;
   logic [63:0]         cnt;
   logic [NUM_BITS-1:0] x_hold;

   logic scl_free;
   logic pnt_free;
   logic fire;
   logic last;
   logic scl_sop;
   logic scl_eop;
   logic host_rdy;
   logic start;
   logic load_scl;
   logic load_x;
   logic load_pnt;
   logic cnt_inc;
   logic set_err;

   assign scl_free = ~o_scl_if.val | o_scl_if.rdy;
   assign pnt_free = ~o_pnt_if.val | o_pnt_if.rdy;
   assign fire     = i_host_if.val & host_rdy;
   assign last     = (cnt == num_r - 64'd1);
   assign scl_sop  = (state == IDLE) | (cnt == 64'd0);
   assign scl_eop  = (state == IDLE) ? (i_num_in == 64'd1) : last;

   assign i_host_if.rdy = host_rdy;

   // A stray sop inside a job is left unconsumed so IDLE can restart on it
   always_comb begin
      host_rdy = 1'b1;
      unique case (state)
         IDLE:    host_rdy = i_host_if.sop ? scl_free : 1'b1;
         SCL:     host_rdy = ~i_host_if.sop & scl_free;
         PX:      host_rdy = ~i_host_if.sop;
         PY:      host_rdy = ~i_host_if.sop & pnt_free;
         DRAIN:   host_rdy = 1'b1;
         default: host_rdy = 1'b1;
      endcase
   end

   always_comb begin
      state_n  = state;
      start    = 1'b0;
      load_scl = 1'b0;
      load_x   = 1'b0;
      load_pnt = 1'b0;
      cnt_inc  = 1'b0;
      set_err  = 1'b0;
      unique case (state)
         IDLE: begin
            if (fire) begin
               if (!i_host_if.sop) begin
                  set_err = 1'b1;
               end else begin
                  start = 1'b1;
                  if (i_num_in == 64'd0) begin
                     set_err = 1'b1;
                     state_n = i_host_if.eop ? IDLE : DRAIN;
                  end else if (i_host_if.eop) begin
                     set_err = 1'b1;
                  end else begin
                     load_scl = 1'b1;
                     state_n  = PX;
                  end
               end
            end
         end
         SCL: begin
            if (i_host_if.val && i_host_if.sop) begin
               set_err = 1'b1;
               state_n = IDLE;
            end else if (fire) begin
               if (i_host_if.eop) begin
                  set_err = 1'b1;
                  state_n = IDLE;
               end else begin
                  load_scl = 1'b1;
                  state_n  = PX;
               end
            end
         end
         PX: begin
            if (i_host_if.val && i_host_if.sop) begin
               set_err = 1'b1;
               state_n = IDLE;
            end else if (fire) begin
               if (i_host_if.eop) begin
                  set_err = 1'b1;
                  state_n = IDLE;
               end else begin
                  load_x  = 1'b1;
                  state_n = PY;
               end
            end
         end
         PY: begin
            if (i_host_if.val && i_host_if.sop) begin
               set_err = 1'b1;
               state_n = IDLE;
            end else if (fire) begin
               if (last) begin
                  load_pnt = 1'b1;
                  set_err  = ~i_host_if.eop;
                  state_n  = i_host_if.eop ? IDLE : DRAIN;
               end else if (i_host_if.eop) begin
                  set_err = 1'b1;
                  state_n = IDLE;
               end else begin
                  load_pnt = 1'b1;
                  cnt_inc  = 1'b1;
                  state_n  = SCL;
               end
            end
         end
         DRAIN: begin
            if (fire && i_host_if.eop) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state        <= IDLE;
         num_r        <= '0;
         cnt          <= '0;
         x_hold       <= '0;
         o_busy       <= 1'b0;
         o_err        <= 1'b0;
         o_scl_if.val <= 1'b0;
         o_scl_if.sop <= 1'b0;
         o_scl_if.eop <= 1'b0;
         o_scl_if.dat <= '0;
         o_pnt_if.val <= 1'b0;
         o_pnt_if.sop <= 1'b0;
         o_pnt_if.eop <= 1'b0;
         o_pnt_if.dat <= '0;
      end else begin
         state  <= state_n;
         o_busy <= (state_n != IDLE);
         if (start) begin
            num_r <= i_num_in;
            cnt   <= '0;
         end else if (cnt_inc) begin
            cnt <= cnt + 64'd1;
         end
         if (set_err) o_err <= 1'b1;
         else if (start) o_err <= 1'b0;
         if (load_x) x_hold <= i_host_if.dat;
         if (load_scl) begin
            o_scl_if.val <= 1'b1;
            o_scl_if.dat <= i_host_if.dat;
            o_scl_if.sop <= scl_sop;
            o_scl_if.eop <= scl_eop;
         end else if (o_scl_if.rdy) begin
            o_scl_if.val <= 1'b0;
         end
         if (load_pnt) begin
            o_pnt_if.val <= 1'b1;
            o_pnt_if.dat <= {i_host_if.dat, x_hold};
            o_pnt_if.sop <= (cnt == 64'd0);
            o_pnt_if.eop <= last;
         end else if (o_pnt_if.rdy) begin
            o_pnt_if.val <= 1'b0;
         end
      end
   end

endmodule
